// File: rtl/axis_gpio_event_logger.sv
// GPIO change logger: masked change detection on an AXI4-Stream sample feed, {timestamp, sample} FIFO drained by an AXI4-Stream master.
// Define AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN to add m_axis_tuser marking the first event after a drop.
module axis_gpio_event_logger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   cfg_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0]            cfg_mask,
    input  logic [AXIS_TDATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    output logic [CNTR_WIDTH+AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
    output logic                                   m_axis_tuser,
`endif
    output logic [31:0]                            sts_drops,
    output logic [$clog2(FIFO_DEPTH):0]            sts_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = CNTR_WIDTH + AXIS_TDATA_WIDTH;
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [CNTR_WIDTH-1:0]       ts;
    logic [AXIS_TDATA_WIDTH-1:0] prev;
    logic                        primed;
    logic [WORD_W-1:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W:0]              level;
    logic [31:0]                 drops;

    logic                        evt_p0;
    logic [WORD_W-1:0]           evt_word_p0;
    logic                        full;
    logic                        pop;
    logic                        push;
    logic                        drop;

    // Stage p0: change detection against the previous sample, combinational in the sample cycle
    assign evt_p0      = s_axis_tvalid & primed & cfg_enable &
                         (((s_axis_tdata ^ prev) & cfg_mask) != '0);
    assign evt_word_p0 = {ts, s_axis_tdata};

    assign full = (level == LVL_FULL);
    assign pop  = m_axis_tvalid & m_axis_tready;
    assign push = evt_p0 & (~full | pop);
    assign drop = evt_p0 & full & ~pop;

    always_ff @(posedge aclk) begin
        if (areset) begin
            ts     <= '0;
            prev   <= '0;
            primed <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            drops  <= '0;
        end else begin
            ts <= ts + CNTR_WIDTH'(1);
            if (s_axis_tvalid) begin
                prev   <= s_axis_tdata;
                primed <= 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                level <= level + (PTR_W+1)'(1);
            else if (pop && !push)
                level <= level - (PTR_W+1)'(1);
            if (drop)
                drops <= sat_inc(drops);
        end
    end

    // Stage p1: FIFO storage; payload needs no reset since the output is gated by occupancy
    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= evt_word_p0;
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = (level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign sts_drops     = drops;
    assign sts_level     = level;

`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
    logic                  lost;
    logic [FIFO_DEPTH-1:0] tuser_mem;

    // Sticky loss flag rides on the next event that makes it into the FIFO
    always_ff @(posedge aclk) begin
        if (areset) begin
            lost      <= 1'b0;
            tuser_mem <= '0;
        end else begin
            if (drop)
                lost <= 1'b1;
            else if (push)
                lost <= 1'b0;
            if (push)
                tuser_mem[wr_ptr] <= lost;
        end
    end

    assign m_axis_tuser = m_axis_tvalid & tuser_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_axis_gpio_event_logger.sv
// Randomized and directed bench for axis_gpio_event_logger against a queue-based reference model.
module tb_axis_gpio_event_logger;

    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_mask = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] sts_drops;
    logic [4:0]  sts_level;
`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
    logic        m_axis_tuser;
`endif

    axis_gpio_event_logger #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH(32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .cfg_enable(cfg_enable),
        .cfg_mask(cfg_mask),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .sts_drops(sts_drops),
        .sts_level(sts_level)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] mq[$];
    bit          mu[$];
    logic [31:0] m_drops;
    logic [31:0] m_ts;
    logic [31:0] m_prev;
    bit          m_primed;
    bit          m_lost;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mu.delete();
        m_drops  = '0;
        m_ts     = '0;
        m_prev   = '0;
        m_primed = 0;
        m_lost   = 0;
    endtask

    task automatic model_eval();
        bit evt;
        bit pop;
        evt = s_axis_tvalid && m_primed && cfg_enable && (((s_axis_tdata ^ m_prev) & cfg_mask) != 0);
        pop = (mq.size() != 0) && m_axis_tready;
        if (pop) begin
            void'(mq.pop_front());
            void'(mu.pop_front());
        end
        if (evt) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({m_ts, s_axis_tdata});
                mu.push_back(m_lost);
                m_lost = 0;
            end else begin
                if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
                m_lost = 1;
            end
        end
        m_ts = m_ts + 1;
        if (s_axis_tvalid) begin
            m_prev   = s_axis_tdata;
            m_primed = 1;
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : 64'd0;
        check("tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
        check("tdata", m_axis_tdata, exp_data);
        check("level", 64'(sts_level), 64'(mq.size()));
        check("drops", 64'(sts_drops), 64'(m_drops));
        check("s_tready", 64'(s_axis_tready), 64'd1);
`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
        check("tuser", 64'(m_axis_tuser), 64'((mu.size() != 0) ? mu[0] : 1'b0));
`endif
    endtask

    // Called just after a falling edge: drive, predict, clock, compare
    task automatic step(input logic en, input logic [31:0] mask, input logic vld,
                        input logic [31:0] data, input logic rdy);
        cfg_enable    = en;
        cfg_mask      = mask;
        s_axis_tvalid = vld;
        s_axis_tdata  = data;
        m_axis_tready = rdy;
        model_eval();
        @(posedge aclk);
        @(negedge aclk);
        compare_all();
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        model_reset();
        check("rst_s_tready", 64'(s_axis_tready), 64'd1);
        compare_all();
        areset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] mask;
        model_reset();
        @(negedge aclk);

        // Prime, no-change, change: one word carrying the third sample's timestamp
        do_reset();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        step(1, 32'hFFFF_FFFF, 1, 32'h0, 1);
        check("prime_no_evt", 64'(m_axis_tvalid), 64'd0);
        step(1, 32'hFFFF_FFFF, 1, 32'h0, 1);
        step(1, 32'hFFFF_FFFF, 1, 32'h1, 1);
        check("first_word", m_axis_tdata, {32'd2, 32'd1});
        check("first_tvalid", 64'(m_axis_tvalid), 64'd1);
        step(1, 32'hFFFF_FFFF, 0, 32'h1, 1);
        check("first_drained", 64'(sts_level), 64'd0);

        // Masked-out bit 8 toggles, bit 2 toggle counts
        do_reset();
        step(1, 32'h0000_000F, 1, 32'h000, 0);
        step(1, 32'h0000_000F, 1, 32'h100, 0);
        step(1, 32'h0000_000F, 1, 32'h104, 0);
        check("mask_level", 64'(sts_level), 64'd1);
        check("mask_drops", 64'(sts_drops), 64'd0);

        // Overflow: 20 changes into 16 slots, then ordered drain
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 32'd0, 0);
        for (int i = 1; i <= 20; i++) step(1, 32'hFFFF_FFFF, 1, 32'(i), 0);
        check("ovf_level", 64'(sts_level), 64'd16);
        check("ovf_drops", 64'(sts_drops), 64'd4);
        check("ovf_head", m_axis_tdata, {32'd1, 32'd1});
        for (int i = 0; i < 16; i++) begin
            check("drain_ts", 64'(m_axis_tdata[63:32]), 64'(i + 1));
            step(1, 32'hFFFF_FFFF, 0, 32'd20, 1);
        end
        check("drain_empty", 64'(m_axis_tvalid), 64'd0);
        step(1, 32'hFFFF_FFFF, 1, 32'd100, 0);
        step(1, 32'hFFFF_FFFF, 1, 32'd101, 1);
`ifdef AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN
        check("tuser_after_drop", 64'(m_axis_tuser), 64'd0);
        check("tuser_second_word", m_axis_tdata, {32'd38, 32'd101});
`endif

        // Full FIFO with simultaneous pop and push
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 32'd0, 0);
        for (int i = 1; i <= 16; i++) step(1, 32'hFFFF_FFFF, 1, 32'(i), 0);
        check("full_level", 64'(sts_level), 64'd16);
        step(1, 32'hFFFF_FFFF, 1, 32'd17, 1);
        check("full_pp_level", 64'(sts_level), 64'd16);
        check("full_pp_drops", 64'(sts_drops), 64'd0);

        // Disabled changes are ignored but still update the reference sample
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 32'd0, 0);
        step(0, 32'hFFFF_FFFF, 1, 32'd1, 0);
        step(0, 32'hFFFF_FFFF, 1, 32'd2, 0);
        step(0, 32'hFFFF_FFFF, 1, 32'd3, 0);
        step(1, 32'hFFFF_FFFF, 1, 32'd3, 0);
        check("en_no_evt", 64'(sts_level), 64'd0);
        step(1, 32'hFFFF_FFFF, 1, 32'd7, 0);
        check("en_evt", 64'(sts_level), 64'd1);

        // Reset with words queued
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 32'd0, 0);
        for (int i = 1; i <= 5; i++) step(1, 32'hFFFF_FFFF, 1, 32'(i), 0);
        check("pre_rst_level", 64'(sts_level), 64'd5);
        do_reset();
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_level", 64'(sts_level), 64'd0);
        step(1, 32'hFFFF_FFFF, 1, 32'd9, 0);
        step(1, 32'hFFFF_FFFF, 1, 32'd8, 0);
        check("ts_restart", m_axis_tdata, {32'd1, 32'd8});

        // Random traffic
        do_reset();
        d = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            case ($urandom_range(0, 2))
                0:       mask = 32'hFFFF_FFFF;
                1:       mask = 32'h0000_000F;
                default: mask = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) d = d ^ (32'd1 << $urandom_range(0, 31));
            step($urandom_range(0, 9) != 0, mask, $urandom_range(0, 3) != 0, d,
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_gpio_event_logger.md
Name: axis_gpio_event_logger

Overview:
Downstream consumer of the GPIO sampler's free-running AXI4-Stream output. Compares each input sample with the previous one under a per-bit mask. On any masked bit change, pushes {timestamp, sample} into an internal FIFO. The FIFO drains through an AXI4-Stream master with full tvalid/tready handshake, towards a DMA writer or a CPU-readable FIFO.

Parameters:
AXIS_TDATA_WIDTH, 32, width of GPIO sample / input stream
CNTR_WIDTH, 32, width of free-running timestamp counter
FIFO_DEPTH, 16, event FIFO entries; power of two, >= 2

Ports:
aclk  input  1  system clock; all logic on rising edge
areset  input  1  synchronous, active-high reset
cfg_enable  input  1  1 = event capture enabled
cfg_mask  input  AXIS_TDATA_WIDTH  1 = bit participates in change detection
s_axis_tdata  input  AXIS_TDATA_WIDTH  GPIO sample
s_axis_tvalid  input  1  sample valid
s_axis_tready  output  1  constant 1; input never stalls
m_axis_tdata  output  CNTR_WIDTH+AXIS_TDATA_WIDTH  event word {timestamp, sample}
m_axis_tvalid  output  1  event word available
m_axis_tready  input  1  downstream accepts word
sts_drops  output  32  count of events lost to FIFO full; saturates at 0xFFFFFFFF
sts_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (clock edge with areset=1): timestamp=0, prev=0, primed=0, FIFO empty, m_axis_tvalid=0, m_axis_tdata=0, sts_drops=0, sts_level=0. s_axis_tready stays 1 during reset.
- Timestamp: increments by 1 every cycle after reset, regardless of cfg_enable. Wraps modulo 2^CNTR_WIDTH without flag.
- Sample register: on every cycle with s_axis_tvalid=1, prev <= s_axis_tdata and primed <= 1. Updates independent of cfg_enable and mask.
- Event condition (cycle N): s_axis_tvalid & primed & cfg_enable & (((s_axis_tdata ^ prev) & cfg_mask) != 0).
- First valid sample after reset only primes; it never produces an event.
- Event word: {timestamp value in cycle N, s_axis_tdata in cycle N}, timestamp in the MSBs.
- FIFO: synchronous, registered, occupancy 0..FIFO_DEPTH.
  - push = event & (not full, or pop in the same cycle).
  - pop = m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop: level unchanged; both proceed.
  - Full with no pop: event dropped; sts_drops += 1 (saturating); FIFO contents unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Output: m_axis_tvalid = (level != 0). m_axis_tdata shows the head entry and is stable while tvalid=1 and tready=0.
- Latency: event in cycle N into an empty FIFO gives m_axis_tvalid=1 in cycle N+1.
- Throughput: one event per cycle accepted and one word per cycle drained.
- cfg_mask and cfg_enable are sampled combinationally in the event cycle. Deasserting cfg_enable does not flush the FIFO; queued words still drain.
- areset mid-operation: queued events discarded, counters cleared, m_axis_tvalid=0 on the next cycle; primed cleared so the next sample only primes.

Optional Feature:
Macro AXIS_GPIO_EVENT_LOGGER_OVERFLOW_FLAG_EN.
- Defined: adds output port m_axis_tuser (1 bit), stored per FIFO entry.
  - Internal sticky lost flag set on any drop.
  - The next successfully pushed event carries tuser=1; flag cleared on that push.
  - Reset clears the flag and stored tuser bits.
- Not defined: port absent, no extra storage; drops visible only via sts_drops.

Test Plan:
- Reset then samples 0x0, 0x0, 0x1 on consecutive valid cycles, mask 0xFFFFFFFF, enable=1, tready=1 -> exactly one word, {ts of third sample, 0x00000001}, tvalid high the cycle after; first sample produces no event.
- mask=0x0000000F, input toggles bit 8 then bit 2 -> one event only (bit-2 change); sts_drops=0.
- tready=0, FIFO_DEPTH=16, 20 consecutive changing samples -> sts_level=16, sts_drops=4, tvalid held with head data stable; release tready -> 16 words drain in order with ascending timestamps.
- FIFO full, tready=1 and new event in same cycle -> push accepted, level stays 16, sts_drops unchanged.
- enable=0 while input changes, then enable=1 with unchanged input -> no events; first change after enable produces an event.
- Assert areset for 1 cycle with 5 words queued -> tvalid=0, sts_level=0, sts_drops=0, timestamp restarts at 0; with macro defined, tuser=1 on first event after an overflow, 0 on the following one.
